// File: rtl/id_ex_alu_issue.sv
// Registered ID/EX issue stage: decodes RV32 ALU ops, selects operand 2, drives the ALU.
// Optional macro ALU_MUL_EN adds MUL decode and the multi-cycle MUL_WAIT hold.
module id_ex_alu_issue #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        illegal_o
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    logic [6:0]      w_opcode;
    logic [6:0]      w_funct7;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_is_mul;
    logic [2:0]      w_ctrl;
    logic [XLEN-1:0] w_data2;
    logic            w_accept;
    logic            w_busy;
    logic            w_unused_ok;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_accept = valid_i & ready_o;

    // Register-source fields are resolved upstream; only data values arrive here.
    assign w_unused_ok = ^{instr_i[19:15], 32'(MUL_LAT), w_is_mul};

    // Decode: ALU control code, legality and operand-2 selection.
    always_comb begin
        w_legal  = 1'b0;
        w_is_mul = 1'b0;
        w_ctrl   = ALU_AND;
        w_data2  = rs2_data_i;
        if (w_opcode == OP_R) begin
            case ({w_funct7, w_funct3})
                {F7_BASE, 3'b111}:   begin w_legal = 1'b1; w_ctrl = ALU_AND; end
                {F7_BASE, 3'b100}:   begin w_legal = 1'b1; w_ctrl = ALU_XOR; end
                {F7_BASE, 3'b001}:   begin w_legal = 1'b1; w_ctrl = ALU_SLL; end
                {F7_BASE, 3'b000}:   begin w_legal = 1'b1; w_ctrl = ALU_ADD; end
                {F7_ALT, 3'b000}:    begin w_legal = 1'b1; w_ctrl = ALU_SUB; end
`ifdef ALU_MUL_EN
                {F7_MULDIV, 3'b000}: begin w_legal = 1'b1; w_ctrl = ALU_MUL; w_is_mul = 1'b1; end
`endif
                default: ;
            endcase
        end else if (w_opcode == OP_I) begin
            if (w_funct3 == 3'b000) begin
                w_legal = 1'b1;
                w_ctrl  = ALU_ADDI;
                w_data2 = {{20{instr_i[31]}}, instr_i[31:20]};
            end else if (w_funct3 == 3'b101 && w_funct7 == F7_ALT) begin
                w_legal = 1'b1;
                w_ctrl  = ALU_SRAI;
                w_data2 = {27'b0, instr_i[24:20]};
            end
        end
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        ST_ISSUE    = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    assign ready_o = ~stall_i & ~rst_i & (r_state == ST_ISSUE);
    assign w_busy  = (r_state == ST_MUL_WAIT);

    // MUL hold: counts the remaining non-stalled cycles the ALU needs.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= ST_ISSUE;
            r_cnt   <= '0;
        end else if (!stall_i) begin
            case (r_state)
                ST_ISSUE: begin
                    if (w_accept && w_is_mul && MUL_LAT > 1) begin
                        r_state <= ST_MUL_WAIT;
                        r_cnt   <= CNT_W'(MUL_LAT - 1);
                    end
                end
                ST_MUL_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_ISSUE;
            endcase
        end
    end
`else
    assign ready_o = ~stall_i & ~rst_i;
    assign w_busy  = 1'b0;
`endif

    // Output registers; data fields only change on a legal accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            illegal_o   <= 1'b0;
            ALUCtrl_o   <= ALU_AND;
            data1_o     <= '0;
            data2_o     <= '0;
            rd_o        <= '0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (!stall_i) begin
            if (w_accept) begin
                if (w_legal) begin
                    valid_o     <= 1'b1;
                    reg_write_o <= (w_rd != 5'd0);
                    illegal_o   <= 1'b0;
                    ALUCtrl_o   <= w_ctrl;
                    data1_o     <= rs1_data_i;
                    data2_o     <= w_data2;
                    rd_o        <= w_rd;
                end else begin
                    valid_o     <= 1'b0;
                    reg_write_o <= 1'b0;
                    illegal_o   <= 1'b1;
                end
            end else if (!w_busy) begin
                valid_o     <= 1'b0;
                reg_write_o <= 1'b0;
                illegal_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed test-plan cases then random traffic
// against a behavioural reference model.
module tb_id_ex_alu_issue;
    localparam int unsigned TB_MUL_LAT = 3;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        ill;
        logic [2:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
    } out_t;

    typedef struct packed {
        logic        legal;
        logic        mul;
        logic [2:0]  ctrl;
        logic [31:0] d2;
    } dec_t;

    // Supported R-type ops: funct7, funct3, ALU code.
    localparam logic [6:0] R_F7 [6] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h01};
    localparam logic [2:0] R_F3 [6] = '{3'd7, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0};
    localparam logic [2:0] R_OP [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    logic        clk = 1'b0;
    logic        rst_i, valid_i, stall_i, flush_i;
    logic [31:0] instr_i, rs1_data_i, rs2_data_i;
    logic        ready_o, valid_o, reg_write_o, illegal_o;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o, data2_o;
    logic [4:0]  rd_o;

    int   tests = 0;
    int   fails = 0;
    out_t sb[$];
    out_t m;
    int   m_wait;
    logic rdy_seen;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.MUL_LAT(TB_MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
        .ALUCtrl_o(ALUCtrl_o), .data1_o(data1_o), .data2_o(data2_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .illegal_o(illegal_o)
    );

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] rs2);
        dec_t d;
        d    = '0;
        d.d2 = rs2;
        if (ins[6:0] == 7'h33) begin
            for (int i = 0; i < 6; i++) begin
                if (ins[31:25] == R_F7[i] && ins[14:12] == R_F3[i] && (MUL_ON || R_OP[i] != 3'd5)) begin
                    d.legal = 1'b1;
                    d.ctrl  = R_OP[i];
                    d.mul   = (R_OP[i] == 3'd5);
                end
            end
        end else if (ins[6:0] == 7'h13) begin
            if (ins[14:12] == 3'd0) begin
                d.legal = 1'b1;
                d.ctrl  = 3'd6;
                d.d2    = ins[31] ? (32'hFFFF_F000 | 32'(ins[31:20])) : 32'(ins[31:20]);
            end else if (ins[14:12] == 3'd5 && ins[31:25] == 7'h20) begin
                d.legal = 1'b1;
                d.ctrl  = 3'd7;
                d.d2    = 32'(ins[24:20]);
            end
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle, check ready_o, advance the reference model, queue the expected output.
    task automatic cyc(input logic r, input logic f, input logic s, input logic v,
                       input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic exp_rdy;
        dec_t d;
        rst_i = r; flush_i = f; stall_i = s; valid_i = v;
        instr_i = ins; rs1_data_i = a; rs2_data_i = b;
        #1;
        exp_rdy  = !s && !r && (m_wait == 0);
        rdy_seen = ready_o;
        chk("ready_o", 32'(ready_o), 32'(exp_rdy));
        if (r) begin
            m = '0; m_wait = 0;
        end else if (f) begin
            m.valid = 1'b0; m.rw = 1'b0; m.ill = 1'b0; m_wait = 0;
        end else if (s) begin
            // everything frozen
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (v) begin
            d = ref_decode(ins, b);
            if (d.legal) begin
                m.valid = 1'b1; m.rw = (ins[11:7] != 5'd0); m.ill = 1'b0;
                m.ctrl = d.ctrl; m.d1 = a; m.d2 = d.d2; m.rd = ins[11:7];
                if (d.mul && TB_MUL_LAT > 1) m_wait = TB_MUL_LAT - 1;
            end else begin
                m.valid = 1'b0; m.rw = 1'b0; m.ill = 1'b1;
            end
        end else begin
            m.valid = 1'b0; m.rw = 1'b0; m.ill = 1'b0;
        end
        if (m.valid || m.ill) sb.push_back(m);
        @(negedge clk);
        #1;
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        out_t got, exp;
        got = '{valid_o, reg_write_o, illegal_o, ALUCtrl_o, data1_o, data2_o, rd_o};
        if (valid_o === 1'b1 || illegal_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got %h expected none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL sb_output: got %h expected %h", got, exp);
                end
            end
        end else if (sb.size() != 0) begin
            tests++;
            fails++;
            exp = sb.pop_front();
            $display("FAIL missing_output: got %h expected %h", got, exp);
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [31:0] w;
        int          k, i;
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        r1 = 5'($urandom);
        r2 = 5'($urandom);
        k  = $urandom_range(0, 9);
        i  = $urandom_range(0, 5);
        case (k)
            0, 1, 2, 3, 4: w = {R_F7[i], r2, r1, R_F3[i], rd, 7'h33};
            5: w = {12'($urandom), r1, 3'd0, rd, 7'h13};
            6: w = {7'h20, r2, r1, 3'd5, rd, 7'h13};
            7: w = {7'($urandom), r2, r1, 3'($urandom), rd, 7'h33};
            8: w = {7'($urandom), r2, r1, 3'($urandom), rd, 7'h13};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        m = '0; m_wait = 0; rdy_seen = 1'b0;
        rst_i = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        instr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        @(negedge clk);
        #1;
        cyc(1, 0, 0, 0, 32'h0, 0, 0);
        cyc(1, 0, 0, 1, 32'h002081B3, 1, 1);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_rw", 32'(reg_write_o), 0);
        chk("rst_ill", 32'(illegal_o), 0);
        chk("rst_ctrl", 32'(ALUCtrl_o), 0);
        chk("rst_d1", data1_o, 0);
        chk("rst_d2", data2_o, 0);
        chk("rst_rd", 32'(rd_o), 0);

        cyc(0, 0, 0, 1, 32'h002081B3, 5, 7);
        chk("add_ctrl", 32'(ALUCtrl_o), 3);
        chk("add_d1", data1_o, 5);
        chk("add_d2", data2_o, 7);
        chk("add_rd", 32'(rd_o), 3);
        chk("add_valid", 32'(valid_o), 1);
        chk("add_rw", 32'(reg_write_o), 1);

        cyc(0, 0, 0, 1, 32'hFFF00093, 0, 32'h1234);
        chk("addi_ctrl", 32'(ALUCtrl_o), 6);
        chk("addi_d2", data2_o, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd_o), 1);
        cyc(0, 0, 0, 1, 32'h40335293, 9, 32'h55);
        chk("srai_ctrl", 32'(ALUCtrl_o), 7);
        chk("srai_d2", data2_o, 3);
        chk("srai_rd", 32'(rd_o), 5);

`ifdef ALU_MUL_EN
        cyc(0, 0, 0, 1, 32'h02208233, 6, 7);
        chk("mul_ctrl", 32'(ALUCtrl_o), 5);
        chk("mul_rd", 32'(rd_o), 4);
        cyc(0, 0, 0, 1, 32'h002081B3, 1, 1);
        chk("mul_wait1_ready", 32'(rdy_seen), 0);
        chk("mul_hold_ctrl", 32'(ALUCtrl_o), 5);
        cyc(0, 0, 0, 1, 32'h002081B3, 1, 1);
        chk("mul_wait2_ready", 32'(rdy_seen), 0);
        cyc(0, 0, 0, 1, 32'h002081B3, 1, 1);
        chk("mul_next_ready", 32'(rdy_seen), 1);
        chk("mul_next_ctrl", 32'(ALUCtrl_o), 3);
`else
        cyc(0, 0, 0, 1, 32'h02208233, 6, 7);
        chk("mul_off_ill", 32'(illegal_o), 1);
        chk("mul_off_valid", 32'(valid_o), 0);
`endif

        cyc(0, 0, 0, 1, 32'hFFFFFFFF, 3, 4);
        chk("ill_pulse", 32'(illegal_o), 1);
        chk("ill_valid", 32'(valid_o), 0);
        chk("ill_rw", 32'(reg_write_o), 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0);
        chk("ill_cleared", 32'(illegal_o), 0);

        cyc(0, 0, 0, 1, 32'h002081B3, 11, 22);
        cyc(0, 0, 1, 1, 32'h402081B3, 1, 2);
        chk("stall1_ready", 32'(rdy_seen), 0);
        cyc(0, 0, 1, 1, 32'h402081B3, 1, 2);
        chk("stall2_ready", 32'(rdy_seen), 0);
        chk("stall_d1", data1_o, 11);
        chk("stall_valid", 32'(valid_o), 1);
        cyc(0, 1, 1, 1, 32'h002081B3, 1, 2);
        chk("flush_valid", 32'(valid_o), 0);

        cyc(0, 0, 0, 1, 32'h00000033, 8, 9);
        chk("x0_valid", 32'(valid_o), 1);
        chk("x0_rw", 32'(reg_write_o), 0);

`ifdef ALU_MUL_EN
        cyc(0, 0, 0, 1, 32'h02208233, 6, 7);
        cyc(1, 0, 0, 1, 32'h002081B3, 1, 1);
        chk("mulrst_valid", 32'(valid_o), 0);
        chk("mulrst_ctrl", 32'(ALUCtrl_o), 0);
        chk("mulrst_d1", data1_o, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0);
        chk("mulrst_ready", 32'(rdy_seen), 1);
`endif

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 75),
                rand_instr(), $urandom, $urandom);
        end
        for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0, 32'h0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

Registered issue stage that sits in front of the ALU, between instruction decode and execute. It accepts one decoded RV32 instruction plus register-file operands per handshake, generates the 3-bit ALU control code, selects and extends the second operand, and drives registered `data1_o`/`data2_o`/`ALUCtrl_o` into the ALU. It also holds issue for multi-cycle MUL, and handles stall, flush and illegal encodings.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles the ALU needs to produce a MUL result; legal range 1–8.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  upstream instruction valid.
- `ready_o`  out  1  issue can accept this cycle.
- `instr_i`  in  32  raw instruction word.
- `rs1_data_i`  in  32  rs1 register value.
- `rs2_data_i`  in  32  rs2 register value.
- `stall_i`  in  1  hazard stall from the hazard unit; freezes stage.
- `flush_i`  in  1  squash stage contents.
- `valid_o`  out  1  registered outputs hold a live instruction.
- `ALUCtrl_o`  out  3  ALU op: AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, ADDI=110, SRAI=111.
- `data1_o`  out  32  ALU operand 1.
- `data2_o`  out  32  ALU operand 2.
- `rd_o`  out  5  destination register.
- `reg_write_o`  out  1  write-back enable.
- `illegal_o`  out  1  one-cycle pulse: unsupported encoding accepted.

## Operation
- Accept = `valid_i & ready_o`; `ready_o = ~stall_i & ~rst_i & (state==ISSUE)`.
- R-type (opcode 0110011), funct7/funct3: 0000000/111 AND, 0000000/100 XOR, 0000000/001 SLL, 0000000/000 ADD, 0100000/000 SUB, 0000001/000 MUL. `data2_o = rs2_data_i`.
- I-type (opcode 0010011): funct3 000 → ADDI, `data2_o` = sign-extended `instr_i[31:20]`; funct3 101 with funct7 0100000 → SRAI, `data2_o = {27'b0, instr_i[24:20]}`.
- `data1_o = rs1_data_i` for all ops. `rd_o = instr_i[11:7]`.
- `reg_write_o = 1` for a legal op with rd≠0. For rd=0: `valid_o = 1`, `reg_write_o = 0`.
- Any other encoding → illegal:
  - `valid_o`, `reg_write_o` = 0 next cycle; `illegal_o` = 1 for exactly that cycle.
  - `ALUCtrl_o`, `data1_o`, `data2_o`, `rd_o` hold their previous values.
- FSM states:
  - ISSUE: accepts. An accepted MUL with `MUL_LAT>1` → MUL_WAIT, loading the counter with `MUL_LAT-1`.
  - MUL_WAIT: outputs hold; the counter decrements each non-stalled cycle; → ISSUE on the cycle the counter reaches 0.
- Cycle with no accept, no stall and no flush: `valid_o`, `reg_write_o`, `illegal_o` cleared; data outputs hold.

## Timing
- Latency 1: accept at edge N → outputs valid after edge N.
- Reset: `valid_o=0`, `reg_write_o=0`, `illegal_o=0`, `ALUCtrl_o=000`, `data1_o=0`, `data2_o=0`, `rd_o=0`, counter=0, state=ISSUE.
- Priority: `rst_i` > `flush_i` > `stall_i` > accept.
- Flush: clears `valid_o`, `reg_write_o`, `illegal_o`, counter → 0, state → ISSUE. Any simultaneous `valid_i` is dropped, including when combined with stall and during MUL_WAIT.
- Stall: every register holds, including the counter and `illegal_o`.
- Reset during MUL_WAIT: returns to ISSUE with reset values the next cycle.
- MUL, `MUL_LAT=L`: `ready_o` is low for L-1 non-stalled cycles after the accept edge, and the MUL outputs stay stable throughout.

## Configuration
- `ALU_MUL_EN` defined: MUL decoded as above; the MUL_WAIT state and counter exist.
- `ALU_MUL_EN` undefined:
  - funct7 0000001 is illegal and raises `illegal_o`.
  - MUL_WAIT and the counter are not built; `ready_o = ~stall_i & ~rst_i`.
  - `MUL_LAT` is ignored.

## Test plan
- Reset, then `instr_i=0x002081B3` (add x3,x1,x2), rs1=5, rs2=7 → next cycle `ALUCtrl_o=011`, `data1_o=5`, `data2_o=7`, `rd_o=3`, `valid_o=1`, `reg_write_o=1`.
- `0xFFF00093` (addi x1,x0,-1) → `ALUCtrl_o=110`, `data2_o=0xFFFFFFFF`, `rd_o=1`. Then `0x40335293` (srai x5,x6,3) → `ALUCtrl_o=111`, `data2_o=3`, `rd_o=5`.
- `ALU_MUL_EN`, `MUL_LAT=3`, `0x02208233` (mul x4,x1,x2), `valid_i` held high → `ALUCtrl_o=101`; `ready_o` low for 2 cycles; next instruction accepted on cycle 3.
- `0xFFFFFFFF` → `illegal_o` high for 1 cycle, `valid_o=0`, `reg_write_o=0`. Without `ALU_MUL_EN`, `0x02208233` behaves the same.
- `stall_i` high for 2 cycles after an add → outputs unchanged, `ready_o=0`. `flush_i` with `stall_i` and `valid_i` all high → `valid_o=0` next cycle.
- `0x00000033` (add x0,x0,x0) → `valid_o=1`, `reg_write_o=0`. Assert `rst_i` mid-MUL_WAIT → all reset values next cycle, `ready_o=1` after release.
